// File: rtl/mips_reg_write_arbiter.sv
// mips_reg_write_arbiter
// Shares the register file's single write port between two writeback requesters
// (req0 = ALU/R-type, req1 = load/multi-cycle unit). Each requester owns a 1-entry
// holding buffer. One buffered write per cycle drains into the registered port outputs.
// Build option: define MIPS_WARB_FIXED_PRIO_EN for fixed priority (req0 wins ties)
// instead of the default round-robin.
module mips_reg_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              signal_reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              busy
);

    logic              buf0_valid_q, buf1_valid_q;
    logic [ADDR_W-1:0] buf0_addr_q, buf1_addr_q;
    logic [DATA_W-1:0] buf0_data_q, buf1_data_q;
    logic              srw_q;
    logic [ADDR_W-1:0] write_reg_q;
    logic [DATA_W-1:0] write_data_q;

    logic              grant0, grant1;
    logic              accept0, accept1;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;

`ifdef MIPS_WARB_FIXED_PRIO_EN
    // Fixed priority: req0 always wins a tie, req1 only drains when req0 is empty.
    always_comb begin
        grant0 = buf0_valid_q;
        grant1 = buf1_valid_q & ~buf0_valid_q;
    end
`else
    logic last_grant_q;

    // Round-robin: on a tie, grant the requester that was not served last.
    always_comb begin
        grant0 = buf0_valid_q & (~buf1_valid_q | last_grant_q);
        grant1 = buf1_valid_q & (~buf0_valid_q | ~last_grant_q);
    end

    // Remember who was served; reset to 1 so req0 wins the first tie. Flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (!flush && (grant0 || grant1)) begin
            last_grant_q <= grant1;
        end
    end
`endif

    // Handshake: a buffer accepts when empty or when it is being drained this cycle.
    always_comb begin
        req0_ready = ~buf0_valid_q | grant0;
        req1_ready = ~buf1_valid_q | grant1;
        accept0    = req0_valid & req0_ready & ~flush;
        accept1    = req1_valid & req1_ready & ~flush;
        grant_addr = grant1 ? buf1_addr_q : buf0_addr_q;
        grant_data = grant1 ? buf1_data_q : buf0_data_q;
    end

    // Requester 0 holding buffer: refill wins over drain, flush wins over both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0_valid_q <= 1'b0;
            buf0_addr_q  <= '0;
            buf0_data_q  <= '0;
        end else if (flush) begin
            buf0_valid_q <= 1'b0;
        end else if (accept0) begin
            buf0_valid_q <= 1'b1;
            buf0_addr_q  <= req0_addr;
            buf0_data_q  <= req0_data;
        end else if (grant0) begin
            buf0_valid_q <= 1'b0;
        end
    end

    // Requester 1 holding buffer: same policy as requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf1_valid_q <= 1'b0;
            buf1_addr_q  <= '0;
            buf1_data_q  <= '0;
        end else if (flush) begin
            buf1_valid_q <= 1'b0;
        end else if (accept1) begin
            buf1_valid_q <= 1'b1;
            buf1_addr_q  <= req1_addr;
            buf1_data_q  <= req1_data;
        end else if (grant1) begin
            buf1_valid_q <= 1'b0;
        end
    end

    // Register-file port: granted entry is registered; writes to $zero never enable the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srw_q        <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else if (flush) begin
            srw_q <= 1'b0;
        end else if (grant0 || grant1) begin
            srw_q        <= (grant_addr != '0);
            write_reg_q  <= grant_addr;
            write_data_q <= grant_data;
        end else begin
            srw_q <= 1'b0;
        end
    end

    // Output drive and activity indication.
    always_comb begin
        signal_reg_write = srw_q;
        write_reg        = write_reg_q;
        write_data       = write_data_q;
        busy             = buf0_valid_q | buf1_valid_q | srw_q;
    end

endmodule

// File: tb/tb_mips_reg_write_arbiter.sv
// Testbench for mips_reg_write_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_mips_reg_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        signal_reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    mips_reg_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .req0_valid       (req0_valid),
        .req0_ready       (req0_ready),
        .req0_addr        (req0_addr),
        .req0_data        (req0_data),
        .req1_valid       (req1_valid),
        .req1_ready       (req1_ready),
        .req1_addr        (req1_addr),
        .req1_data        (req1_data),
        .signal_reg_write (signal_reg_write),
        .write_reg        (write_reg),
        .write_data       (write_data),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic fl);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        flush      = fl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        tests_run++; if (signal_reg_write !== 1'b0) begin tests_failed++; $display("FAIL reset_srw got %b want 0", signal_reg_write); end
        tests_run++; if (write_reg !== 5'd0) begin tests_failed++; $display("FAIL reset_write_reg got %0d want 0", write_reg); end
        tests_run++; if (write_data !== 32'd0) begin tests_failed++; $display("FAIL reset_write_data got %h want 0", write_data); end
        tests_run++; if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req0_ready got %b want 1", req0_ready); end
        tests_run++; if (req1_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req1_ready got %b want 1", req1_ready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        tests_run++; if (signal_reg_write !== 1'b0) begin tests_failed++; $display("FAIL single_srw_early got %b want 0", signal_reg_write); end
        @(negedge clk);
        tests_run++; if (signal_reg_write !== 1'b1) begin tests_failed++; $display("FAIL single_srw got %b want 1", signal_reg_write); end
        tests_run++; if (write_reg !== 5'd5) begin tests_failed++; $display("FAIL single_write_reg got %0d want 5", write_reg); end
        tests_run++; if (write_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL single_write_data got %h want deadbeef", write_data); end
        @(negedge clk);
        tests_run++; if (signal_reg_write !== 1'b0) begin tests_failed++; $display("FAIL single_srw_after got %b want 0", signal_reg_write); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after got %b want 0", busy); end
    endtask

    task automatic test_contention();
        int i0 = 0;
        int i1 = 0;
        int cyc = 0;
        int got[$];
        int exp_seq[$];
        bit h0, h1;
`ifdef MIPS_WARB_FIXED_PRIO_EN
        exp_seq = '{1, 2, 3, 4, 9, 10, 11, 12};
`else
        exp_seq = '{1, 9, 2, 10, 3, 11, 4, 12};
`endif
        do_reset();
        while (cyc < 40 && !(i0 == 4 && i1 == 4 && got.size() == 8 && busy == 1'b0)) begin
            @(negedge clk);
            if (signal_reg_write === 1'b1) got.push_back(int'(write_reg));
            drive(i0 < 4, 5'(i0 + 1), 32'h100 + 32'(i0), i1 < 4, 5'(i1 + 9), 32'h900 + 32'(i1), 0);
            #1;
            h0 = (i0 < 4) && req0_ready;
            h1 = (i1 < 4) && req1_ready;
            @(posedge clk);
            if (h0) i0++;
            if (h1) i1++;
            cyc++;
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tests_run++; if (got.size() != 8) begin tests_failed++; $display("FAIL contention_count got %0d want 8", got.size()); end
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (k >= got.size()) begin
                tests_failed++; $display("FAIL contention_seq[%0d] got none want %0d", k, exp_seq[k]);
            end else if (got[k] != exp_seq[k]) begin
                tests_failed++; $display("FAIL contention_seq[%0d] got %0d want %0d", k, got[k], exp_seq[k]);
            end
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(0, 0, 0, 1, 0, 32'h1234, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        tests_run++; if (signal_reg_write !== 1'b0) begin tests_failed++; $display("FAIL zero_srw_a got %b want 0", signal_reg_write); end
        @(negedge clk);
        tests_run++; if (signal_reg_write !== 1'b0) begin tests_failed++; $display("FAIL zero_srw_b got %b want 0", signal_reg_write); end
        tests_run++; if (write_data !== 32'h1234) begin tests_failed++; $display("FAIL zero_granted_data got %h want 1234", write_data); end
        tests_run++; if (req1_ready !== 1'b1) begin tests_failed++; $display("FAIL zero_req1_ready got %b want 1", req1_ready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL zero_busy got %b want 0", busy); end
    endtask

    task automatic test_flush_reset();
        int writes = 0;
        do_reset();
        drive(1, 3, 32'hAAAA, 1, 7, 32'hBBBB, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy got %b want 0", busy); end
        tests_run++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_ready got %b%b want 11", req0_ready, req1_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (signal_reg_write === 1'b1) writes++;
        end
        tests_run++; if (writes != 0) begin tests_failed++; $display("FAIL flush_no_writes got %0d want 0", writes); end

        do_reset();
        drive(1, 3, 32'hAAAA, 1, 7, 32'hBBBB, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tests_run++; if (signal_reg_write !== 1'b1) begin tests_failed++; $display("FAIL midop_pre_srw got %b want 1", signal_reg_write); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (signal_reg_write !== 1'b0) begin tests_failed++; $display("FAIL midop_rst_srw got %b want 0", signal_reg_write); end
        tests_run++; if (write_reg !== 5'd0 || write_data !== 32'd0) begin tests_failed++; $display("FAIL midop_rst_port got %0d/%h want 0/0", write_reg, write_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midop_rst_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int wcyc[$];
        int wreg[$];
        logic [31:0] wdat[$];
        logic [31:0] sent[8];
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (signal_reg_write === 1'b1) begin
                wcyc.push_back(c); wreg.push_back(int'(write_reg)); wdat.push_back(write_data);
            end
            if (c < 8) begin
                sent[c] = $urandom;
                drive(1, 5'(c + 1), sent[c], 0, 0, 0, 0);
                #1;
                tests_run++; if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_ready[%0d] got %b want 1", c, req0_ready); end
            end else begin
                drive(0, 0, 0, 0, 0, 0, 0);
            end
        end
        tests_run++; if (wcyc.size() != 8) begin tests_failed++; $display("FAIL stream_count got %0d want 8", wcyc.size()); end
        for (int k = 0; k < 8 && k < wcyc.size(); k++) begin
            tests_run++;
            if (wcyc[k] != k + 2 || wreg[k] != k + 1 || wdat[k] !== sent[k]) begin
                tests_failed++;
                $display("FAIL stream_write[%0d] got cyc %0d reg %0d data %h want cyc %0d reg %0d data %h",
                         k, wcyc[k], wreg[k], wdat[k], k + 2, k + 1, sent[k]);
            end
        end
    endtask

    // Reference model: each buffer is a pending transaction; at every edge the arbiter
    // serves at most one pending transaction, alternating on ties, and then new offers
    // are taken into whichever slot is free (or being freed).
    task automatic test_random();
        bit          pend[2];
        logic [4:0]  paddr[2];
        logic [31:0] pdata[2];
        int          last_served;
        bit          exp_we;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        int          served;
        bit          rdy[2];
        bit          v[2];
        logic [4:0]  a[2];
        logic [31:0] d[2];
        bit          fl;
        do_reset();
        pend = '{0, 0}; last_served = 1; exp_we = 0; exp_reg = 0; exp_data = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            tests_run++; if (signal_reg_write !== exp_we) begin tests_failed++; $display("FAIL rand_srw c%0d got %b want %b", c, signal_reg_write, exp_we); end
            tests_run++; if (write_reg !== exp_reg) begin tests_failed++; $display("FAIL rand_write_reg c%0d got %0d want %0d", c, write_reg, exp_reg); end
            tests_run++; if (write_data !== exp_data) begin tests_failed++; $display("FAIL rand_write_data c%0d got %h want %h", c, write_data, exp_data); end
            tests_run++; if (busy !== (pend[0] | pend[1] | exp_we)) begin tests_failed++; $display("FAIL rand_busy c%0d got %b want %b", c, busy, pend[0] | pend[1] | exp_we); end
            for (int i = 0; i < 2; i++) begin
                v[i] = ($urandom_range(0, 3) != 0);
                a[i] = 5'($urandom_range(0, 31));
                d[i] = $urandom;
            end
            fl = ($urandom_range(0, 15) == 0);
            drive(v[0], a[0], d[0], v[1], a[1], d[1], fl);
            if (pend[0] && pend[1]) begin
`ifdef MIPS_WARB_FIXED_PRIO_EN
                served = 0;
`else
                served = 1 - last_served;
`endif
            end else if (pend[0]) served = 0;
            else if (pend[1]) served = 1;
            else served = -1;
            rdy[0] = !pend[0] || served == 0;
            rdy[1] = !pend[1] || served == 1;
            #1;
            tests_run++; if (req0_ready !== rdy[0]) begin tests_failed++; $display("FAIL rand_req0_ready c%0d got %b want %b", c, req0_ready, rdy[0]); end
            tests_run++; if (req1_ready !== rdy[1]) begin tests_failed++; $display("FAIL rand_req1_ready c%0d got %b want %b", c, req1_ready, rdy[1]); end
            if (fl) begin
                pend = '{0, 0};
                exp_we = 0;
            end else begin
                if (served >= 0) begin
                    exp_we      = (paddr[served] != 0);
                    exp_reg     = paddr[served];
                    exp_data    = pdata[served];
                    last_served = served;
                    pend[served] = 0;
                end else begin
                    exp_we = 0;
                end
                for (int i = 0; i < 2; i++) begin
                    if (v[i] && rdy[i]) begin
                        pend[i] = 1; paddr[i] = a[i]; pdata[i] = d[i];
                    end
                end
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_zero_reg();
        test_flush_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
